median_frame_ctrl: RTL and testbench

Frame-level sequencer for the median filter datapath. On `frame_start` it walks a 3x3 window across the image in raster order. For each window position it runs three steps: hold `win_start` for the window counter until `windowValid`, pulse `sort_start` to the median sorter until `sort_done`, then present the median with its centre coordinates on a valid/ready output port. It asserts `frame_done` once after the last window and sits between the top-level frame trigger and the windowCounter/sorter pair.

---
 rtl/median_frame_ctrl.sv | 121 ++++++++++++
 tb/tb_median_frame_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/median_frame_ctrl.sv
// Frame sequencer for the median filter: walks a 3x3 window over the image in raster
// order, handshaking with the window counter, the sorter and a valid/ready output port.
module median_frame_ctrl #(
   parameter int IMG_W   = 8,
   parameter int IMG_H   = 8,
   parameter int COORD_W = 8,
   parameter int DATA_W  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_start,
   input  logic               abort,
   input  logic               win_valid,
   input  logic               sort_done,
   input  logic [DATA_W-1:0]  median_in,
   input  logic               out_ready,
   output logic               win_start,
   output logic               sort_start,
   output logic [COORD_W-1:0] win_x,
   output logic [COORD_W-1:0] win_y,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_pixel,
   output logic [COORD_W-1:0] out_x,
   output logic [COORD_W-1:0] out_y,
   output logic               busy,
   output logic               frame_done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SORT  = 3'd2,
      WRITE = 3'd3,
      ADV   = 3'd4,
      DONE  = 3'd5
   } state_t;

   // Last legal top-left corner in each direction.
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 3);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 3);
   localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

   state_t state;
   state_t state_next;
   logic   x_more;
   logic   y_more;
   logic   cancel;

   assign x_more = (win_x < X_LAST);
   assign y_more = (win_y < Y_LAST);
   assign cancel = abort && (state != IDLE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (cancel) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (frame_start) state_next = LOAD;
            LOAD:    if (win_valid)   state_next = SORT;
            SORT:    if (sort_done)   state_next = WRITE;
            WRITE:   if (out_ready)   state_next = ADV;
            ADV:     state_next = (x_more || y_more) ? LOAD : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Abort returns every register to its reset value, exactly like reset.
   always_ff @(posedge clk) begin
      if (!reset || cancel) begin
         sort_start <= 1'b0;
         win_x      <= '0;
         win_y      <= '0;
         out_pixel  <= '0;
         out_x      <= '0;
         out_y      <= '0;
      end else begin
         sort_start <= (state == LOAD) && win_valid;
         case (state)
            IDLE: begin
               if (frame_start) begin
                  win_x <= '0;
                  win_y <= '0;
               end
            end
            SORT: begin
               if (sort_done) begin
                  out_pixel <= median_in;
                  out_x     <= win_x + ONE;
                  out_y     <= win_y + ONE;
               end
            end
            ADV: begin
               if (x_more) begin
                  win_x <= win_x + ONE;
               end else if (y_more) begin
                  win_x <= '0;
                  win_y <= win_y + ONE;
               end
            end
            default: ;
         endcase
      end
   end

   assign win_start  = (state == LOAD);
   assign out_valid  = (state == WRITE);
   assign busy       = (state != IDLE);
   assign frame_done = (state == DONE);

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Scoreboard bench for median_frame_ctrl: responders model the window counter and
// sorter, a monitor checks every output handshake against raster-order coordinates.
module tb_median_frame_ctrl;

   localparam int IMG_W   = 8;
   localparam int IMG_H   = 8;
   localparam int COORD_W = 8;
   localparam int DATA_W  = 8;
   localparam int WINDOWS = (IMG_W - 2) * (IMG_H - 2);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset = 1'b0;
   logic               frame_start = 1'b0;
   logic               abort = 1'b0;
   logic               out_ready = 1'b1;
   logic               win_valid_rsp = 1'b0;
   logic               win_valid_spur = 1'b0;
   logic               sort_done_rsp = 1'b0;
   logic               sort_done_spur = 1'b0;
   logic               win_valid;
   logic               sort_done;
   logic [DATA_W-1:0]  median_in = '0;
   logic               win_start;
   logic               sort_start;
   logic [COORD_W-1:0] win_x;
   logic [COORD_W-1:0] win_y;
   logic               out_valid;
   logic [DATA_W-1:0]  out_pixel;
   logic [COORD_W-1:0] out_x;
   logic [COORD_W-1:0] out_y;
   logic               busy;
   logic               frame_done;

   assign win_valid = win_valid_rsp | win_valid_spur;
   assign sort_done = sort_done_rsp | sort_done_spur;

   median_frame_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .COORD_W(COORD_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start), .abort(abort),
      .win_valid(win_valid), .sort_done(sort_done), .median_in(median_in),
      .out_ready(out_ready), .win_start(win_start), .sort_start(sort_start),
      .win_x(win_x), .win_y(win_y), .out_valid(out_valid), .out_pixel(out_pixel),
      .out_x(out_x), .out_y(out_y), .busy(busy), .frame_done(frame_done)
   );

   // Minimum 3x3 image with zero-latency neighbours.
   logic               frame_start3 = 1'b0;
   logic               abort3 = 1'b0;
   logic               win_valid3 = 1'b0;
   logic               sort_done3 = 1'b0;
   logic [DATA_W-1:0]  median3 = '0;
   logic               out_ready3 = 1'b1;
   logic               win_start3;
   logic               sort_start3;
   logic [COORD_W-1:0] win_x3;
   logic [COORD_W-1:0] win_y3;
   logic               out_valid3;
   logic [DATA_W-1:0]  out_pixel3;
   logic [COORD_W-1:0] out_x3;
   logic [COORD_W-1:0] out_y3;
   logic               busy3;
   logic               frame_done3;

   median_frame_ctrl #(.IMG_W(3), .IMG_H(3), .COORD_W(COORD_W), .DATA_W(DATA_W)) dut3 (
      .clk(clk), .reset(reset), .frame_start(frame_start3), .abort(abort3),
      .win_valid(win_valid3), .sort_done(sort_done3), .median_in(median3),
      .out_ready(out_ready3), .win_start(win_start3), .sort_start(sort_start3),
      .win_x(win_x3), .win_y(win_y3), .out_valid(out_valid3), .out_pixel(out_pixel3),
      .out_x(out_x3), .out_y(out_y3), .busy(busy3), .frame_done(frame_done3)
   );

   int errors = 0;
   int checks = 0;
   int cycle = 0;
   int hs_count = 0;
   int last_hs = 0;
   int done_count = 0;
   int sort_start_count = 0;
   int exp_x[$];
   int exp_y[$];
   int med_q[$];
   int w_lat = 1;
   int s_lat = 1;
   bit rand_lat = 1'b0;
   int w_cnt = 0;
   int w_cur = 0;
   int s_cnt = 0;
   int s_cur = 0;
   bit s_armed = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a frame on the main DUT and queues the raster-order centre coordinates.
   task automatic applyStimulus();
      for (int y = 0; y <= IMG_H - 3; y++) begin
         for (int x = 0; x <= IMG_W - 3; x++) begin
            exp_x.push_back(x + 1);
            exp_y.push_back(y + 1);
         end
      end
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      @(negedge clk);
      checkOutput("start_busy", busy, 1);
      checkOutput("start_win_start", win_start, 1);
      checkOutput("start_win_x", win_x, 0);
      checkOutput("start_win_y", win_y, 0);
   endtask

   task automatic flushScoreboard();
      exp_x.delete();
      exp_y.delete();
      med_q.delete();
   endtask

   task automatic waitDone(input int d0, input int budget, input bit rand_ready);
      int n;
      n = 0;
      while (done_count == d0 && n < budget) begin
         tick();
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
         n++;
      end
      out_ready = 1'b1;
      checkOutput("frame_done_within_budget", done_count != d0, 1);
      repeat (4) tick();
   endtask

   task automatic checkIdleZero(input string tag);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_win_start"}, win_start, 0);
      checkOutput({tag, "_sort_start"}, sort_start, 0);
      checkOutput({tag, "_out_valid"}, out_valid, 0);
      checkOutput({tag, "_frame_done"}, frame_done, 0);
      checkOutput({tag, "_win_x"}, win_x, 0);
      checkOutput({tag, "_win_y"}, win_y, 0);
      checkOutput({tag, "_out_pixel"}, out_pixel, 0);
      checkOutput({tag, "_out_x"}, out_x, 0);
      checkOutput({tag, "_out_y"}, out_y, 0);
   endtask

   // Window counter model: raises win_valid for one cycle after a (possibly random) delay.
   always @(posedge clk) begin
      #1;
      win_valid_rsp = 1'b0;
      if (!win_start) begin
         w_cnt = 0;
      end else begin
         if (w_cnt == 0) w_cur = rand_lat ? int'($urandom_range(0, 3)) : w_lat;
         if (w_cnt >= w_cur) win_valid_rsp = 1'b1;
         else w_cnt++;
      end
   end

   // Sorter model: returns a random median after a delay and records it as expected data.
   always @(posedge clk) begin
      #1;
      sort_done_rsp = 1'b0;
      if (!busy) begin
         s_armed = 1'b0;
      end else if (sort_start) begin
         s_armed = 1'b1;
         s_cnt = 0;
         s_cur = rand_lat ? int'($urandom_range(0, 3)) : s_lat;
      end
      if (s_armed) begin
         if (s_cnt >= s_cur) begin
            sort_done_rsp = 1'b1;
            median_in = DATA_W'($urandom);
            med_q.push_back(int'(median_in));
            s_armed = 1'b0;
         end else begin
            s_cnt++;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      win_valid3 = win_start3;
      sort_done3 = sort_start3;
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      cycle++;
      if (sort_start) sort_start_count++;
      if (out_valid && out_ready) begin
         hs_count++;
         last_hs = cycle;
         checkOutput("scoreboard_has_entry", (exp_x.size() > 0) && (med_q.size() > 0), 1);
         if (exp_x.size() > 0 && med_q.size() > 0) begin
            checkOutput("hs_out_x", out_x, exp_x.pop_front());
            checkOutput("hs_out_y", out_y, exp_y.pop_front());
            checkOutput("hs_out_pixel", out_pixel, med_q.pop_front());
         end
      end
      if (frame_done) begin
         done_count++;
         checkOutput("frame_done_latency", cycle - last_hs, 2);
         checkOutput("frame_done_all_windows", exp_x.size(), 0);
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int hs0;
      int d0;
      int s0;
      int n;
      int hs3;
      int hs3_at;
      int dn3;
      int dn3_at;

      $display("[TB] reset");
      repeat (3) tick();
      @(negedge clk);
      checkIdleZero("reset");
      checkOutput("reset_busy3", busy3, 0);
      tick();
      reset = 1'b1;

      $display("[TB] full frame, fixed latencies, out_ready tied");
      rand_lat = 1'b0; w_lat = 1; s_lat = 1;
      hs0 = hs_count; d0 = done_count; s0 = sort_start_count;
      applyStimulus();
      waitDone(d0, 3000, 1'b0);
      checkOutput("full_handshakes", hs_count - hs0, WINDOWS);
      checkOutput("full_frame_done_count", done_count - d0, 1);
      checkOutput("full_sort_starts", sort_start_count - s0, WINDOWS);
      checkOutput("full_busy_after", busy, 0);

      $display("[TB] reset held during LOAD");
      w_lat = 3;
      applyStimulus();
      tick();
      reset = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      checkIdleZero("reset_load");
      tick();
      flushScoreboard();
      reset = 1'b1;
      rand_lat = 1'b1;
      hs0 = hs_count; d0 = done_count;
      applyStimulus();

      $display("[TB] backpressure at (3,2)");
      n = 0;
      while (!(out_valid && out_x == 3 && out_y == 2) && n < 2000) begin
         tick();
         n++;
      end
      checkOutput("bp_window_reached", out_valid && out_x == 3 && out_y == 2, 1);
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("bp_out_valid", out_valid, 1);
         checkOutput("bp_out_x", out_x, 3);
         checkOutput("bp_out_y", out_y, 2);
         if (med_q.size() > 0) checkOutput("bp_out_pixel", out_pixel, med_q[0]);
         tick();
      end
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      checkOutput("bp_adv_out_valid", out_valid, 0);
      checkOutput("bp_adv_win_start", win_start, 0);
      checkOutput("bp_adv_busy", busy, 1);
      tick();
      @(negedge clk);
      checkOutput("bp_next_win_start", win_start, 1);
      checkOutput("bp_next_win_x", win_x, 3);
      checkOutput("bp_next_win_y", win_y, 1);
      waitDone(d0, 5000, 1'b1);
      checkOutput("bp_handshakes", hs_count - hs0, WINDOWS);
      checkOutput("bp_frame_done_count", done_count - d0, 1);

      $display("[TB] spurious inputs and abort");
      rand_lat = 1'b0; w_lat = 3; s_lat = 3;
      hs0 = hs_count; d0 = done_count; s0 = sort_start_count;
      applyStimulus();
      tick();
      sort_done_spur = 1'b1;
      tick();
      sort_done_spur = 1'b0;
      @(negedge clk);
      checkOutput("spur_load_win_start", win_start, 1);
      checkOutput("spur_load_out_valid", out_valid, 0);
      checkOutput("spur_load_sort_start", sort_start, 0);
      n = 0;
      while (!sort_start && n < 50) begin
         tick();
         n++;
      end
      win_valid_spur = 1'b1;
      tick();
      win_valid_spur = 1'b0;
      @(negedge clk);
      checkOutput("spur_sort_sort_start", sort_start, 0);
      checkOutput("spur_sort_win_start", win_start, 0);
      checkOutput("spur_sort_out_valid", out_valid, 0);
      checkOutput("spur_sort_busy", busy, 1);
      w_lat = 1; s_lat = 1;
      n = 0;
      while (!(hs_count - hs0 == 4 && sort_start) && n < 1000) begin
         tick();
         n++;
      end
      checkOutput("abort_window5_sort", sort_start, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      @(negedge clk);
      checkIdleZero("abort");
      flushScoreboard();
      repeat (6) tick();
      checkOutput("abort_no_frame_done", done_count - d0, 0);
      checkOutput("abort_sort_starts", sort_start_count - s0, 5);
      checkOutput("abort_handshakes", hs_count - hs0, 4);

      $display("[TB] restart after abort, random latencies and readiness");
      rand_lat = 1'b1;
      hs0 = hs_count; d0 = done_count;
      applyStimulus();
      waitDone(d0, 6000, 1'b1);
      checkOutput("restart_handshakes", hs_count - hs0, WINDOWS);
      checkOutput("restart_frame_done_count", done_count - d0, 1);

      $display("[TB] minimum 3x3 image");
      median3 = DATA_W'($urandom);
      frame_start3 = 1'b1;
      tick();
      frame_start3 = 1'b0;
      hs3 = 0; hs3_at = -100; dn3 = 0; dn3_at = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (out_valid3 && out_ready3) begin
            hs3++;
            hs3_at = c;
            checkOutput("min_out_x", out_x3, 1);
            checkOutput("min_out_y", out_y3, 1);
            checkOutput("min_out_pixel", out_pixel3, median3);
         end
         if (frame_done3) begin
            dn3++;
            dn3_at = c;
            checkOutput("min_done_win_x", win_x3, 0);
            checkOutput("min_done_win_y", win_y3, 0);
         end
         tick();
      end
      checkOutput("min_windows", hs3, 1);
      checkOutput("min_frame_done_count", dn3, 1);
      checkOutput("min_frame_done_latency", dn3_at - hs3_at, 2);
      checkOutput("min_busy_after", busy3, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
